// File: rtl/servo_slew_ctrl.sv
// Slew-limited position command stage for the servo PWM generator.
// Accepts clamped targets over valid/ready and steps the position toward them once per tick.
module servo_slew_ctrl #(
  parameter int unsigned STEP_DIV     = 1000000,
  parameter int unsigned STEP         = 1,
  parameter int unsigned SETTLE_TICKS = 20,
  parameter int unsigned INIT_POS     = 128,
  parameter int unsigned POS_MIN      = 0,
  parameter int unsigned POS_MAX      = 255
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_pos,
  output logic       o_cmd_ready,
  input  logic       i_hold,
  output logic [7:0] o_pos,
  output logic       o_busy,
  output logic       o_at_target
);

  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE   = PW'(1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [7:0]    POS_LO      = 8'(POS_MIN);
  localparam logic [7:0]    POS_HI      = 8'(POS_MAX);
  localparam logic [7:0]    POS_INIT    = 8'(INIT_POS);
  localparam logic [7:0]    STEP_8      = 8'(STEP);
  localparam logic [8:0]    STEP_9      = 9'(STEP);

  typedef enum logic [1:0] {StIdle, StMove, StSettle} state_e;

  state_e        r_state, w_state_d;
  logic [7:0]    r_pos, w_pos_d;
  logic [7:0]    r_target, w_target_d;
  logic [PW-1:0] r_presc, w_presc_d;
  logic [SW-1:0] r_settle, w_settle_d;

  logic [7:0]    w_cmd_clamped;
  logic          w_accept;
  logic [8:0]    w_delta;
  logic [8:0]    w_dist;
  logic          w_near;
  logic          w_presc_last;
  logic          w_tick;
  logic [SW-1:0] w_settle_inc;

  // Inclusive compares keep the lower bound well-formed when POS_MIN is 0.
  assign w_cmd_clamped = (i_cmd_pos <= POS_LO) ? POS_LO :
                         (i_cmd_pos >= POS_HI) ? POS_HI : i_cmd_pos;

  assign w_accept     = i_cmd_valid & o_cmd_ready;
  assign w_delta      = {1'b0, r_target} - {1'b0, r_pos};
  assign w_dist       = w_delta[8] ? (~w_delta + 9'd1) : w_delta;
  assign w_near       = (w_dist <= STEP_9);
  assign w_presc_last = (r_presc == PRESC_LAST);
  assign w_tick       = w_presc_last & (((r_state == StMove) & ~i_hold) | (r_state == StSettle));
  assign w_settle_inc = r_settle + SETTLE_ONE;

  always_comb begin
    w_state_d  = r_state;
    w_pos_d    = r_pos;
    w_target_d = w_accept ? w_cmd_clamped : r_target;
    w_presc_d  = r_presc;
    w_settle_d = r_settle;

    unique case (r_state)
      StIdle: begin
        w_presc_d = '0;
        if (w_accept && (w_cmd_clamped != r_pos)) begin
          w_state_d = StMove;
        end
      end

      StMove: begin
        if (!i_hold) begin
          w_presc_d = w_presc_last ? '0 : (r_presc + PRESC_ONE);
        end
        // A tick always steers by the pre-accept target; a retarget lands next tick.
        if (w_tick) begin
          if (w_near) begin
            w_pos_d    = r_target;
            w_presc_d  = '0;
            w_settle_d = '0;
            w_state_d  = (SETTLE_TICKS == 0) ? StIdle : StSettle;
          end else if (w_delta[8]) begin
            w_pos_d = r_pos - STEP_8;
          end else begin
            w_pos_d = r_pos + STEP_8;
          end
        end
      end

      StSettle: begin
        w_presc_d = w_presc_last ? '0 : (r_presc + PRESC_ONE);
        if (w_tick) begin
          w_settle_d = w_settle_inc;
          if (w_settle_inc == SETTLE_LAST) begin
            w_state_d = StIdle;
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_state  <= StIdle;
      r_pos    <= POS_INIT;
      r_target <= POS_INIT;
      r_presc  <= '0;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_d;
      r_pos    <= w_pos_d;
      r_target <= w_target_d;
      r_presc  <= w_presc_d;
      r_settle <= w_settle_d;
    end
  end

  assign o_pos       = r_pos;
  assign o_cmd_ready = (r_state != StSettle);
  assign o_busy      = (r_state != StIdle);
  assign o_at_target = (r_state == StIdle);

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Bench for servo_slew_ctrl: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a tick-countdown model of the slew behaviour.
module tb_servo_slew_ctrl;

  localparam int unsigned STEP_DIV     = 4;
  localparam int unsigned STEP         = 3;
  localparam int unsigned SETTLE_TICKS = 2;
  localparam int unsigned INIT_POS     = 128;
  localparam int unsigned POS_MIN      = 20;
  localparam int unsigned POS_MAX      = 230;

  logic       clk = 1'b0;
  logic       i_clr = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic [7:0] i_cmd_pos = 8'd0;
  logic       i_hold = 1'b0;
  logic       o_cmd_ready;
  logic [7:0] o_pos;
  logic       o_busy;
  logic       o_at_target;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: phase 0 idle, 1 moving, 2 settling; m_wait counts cycles left until the next tick.
  int m_phase, m_pos, m_tgt, m_wait, m_left;

  servo_slew_ctrl #(
    .STEP_DIV    (STEP_DIV),
    .STEP        (STEP),
    .SETTLE_TICKS(SETTLE_TICKS),
    .INIT_POS    (INIT_POS),
    .POS_MIN     (POS_MIN),
    .POS_MAX     (POS_MAX)
  ) dut (
    .i_clk      (clk),
    .i_clr      (i_clr),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_pos  (i_cmd_pos),
    .o_cmd_ready(o_cmd_ready),
    .i_hold     (i_hold),
    .o_pos      (o_pos),
    .o_busy     (o_busy),
    .o_at_target(o_at_target)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < int'(POS_MIN)) return POS_MIN;
    if (v > int'(POS_MAX)) return POS_MAX;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model, advanced once per clock edge or immediately on reset.
  initial begin
    m_phase = 0; m_pos = INIT_POS; m_tgt = INIT_POS; m_wait = STEP_DIV; m_left = 0;
    forever begin
      @(posedge clk or negedge i_clr);
      if (!i_clr) begin
        m_phase = 0; m_pos = INIT_POS; m_tgt = INIT_POS; m_wait = STEP_DIV; m_left = 0;
      end else begin
        int  old_phase;
        bit  acc;
        int  ct;
        old_phase = m_phase;
        acc = i_cmd_valid && (m_phase != 2);
        ct  = clampi(int'(i_cmd_pos));
        if ((m_phase == 1 && !i_hold) || m_phase == 2) begin
          m_wait--;
          if (m_wait == 0) begin
            m_wait = STEP_DIV;
            if (m_phase == 1) begin
              if (absi(m_tgt - m_pos) <= int'(STEP)) begin
                m_pos   = m_tgt;
                m_left  = SETTLE_TICKS;
                m_phase = (SETTLE_TICKS == 0) ? 0 : 2;
              end else begin
                m_pos = (m_tgt > m_pos) ? m_pos + STEP : m_pos - STEP;
              end
            end else begin
              m_left--;
              if (m_left == 0) m_phase = 0;
            end
          end
        end
        if (acc) begin
          m_tgt = ct;
          if (old_phase == 0 && ct != m_pos) begin
            m_phase = 1;
            m_wait  = STEP_DIV;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("pos", int'(o_pos), m_pos);
      check("busy", int'(o_busy), (m_phase != 0) ? 1 : 0);
      check("at_target", int'(o_at_target), (m_phase == 0) ? 1 : 0);
      check("cmd_ready", int'(o_cmd_ready), (m_phase != 2) ? 1 : 0);
      if (o_pos < 8'(POS_MIN) || o_pos > 8'(POS_MAX)) check("pos_range", int'(o_pos), m_pos + 1000);
    end
  end

  task automatic send(input int p);
    i_cmd_valid = 1'b1;
    i_cmd_pos   = 8'(p);
    for (int i = 0; i < 200 && !o_cmd_ready; i++) @(negedge clk);
    if (!o_cmd_ready) check("send_timeout", 0, 1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && !o_at_target; i++) @(negedge clk);
    if (!o_at_target) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 500 && int'(o_pos) != p; i++) @(negedge clk);
    if (int'(o_pos) != p) check("pos_wait_timeout", int'(o_pos), p);
  endtask

  task automatic wait_change(input int prev);
    for (int i = 0; i < 100 && int'(o_pos) == prev; i++) @(negedge clk);
  endtask

  initial begin
    int exp_seq[5];
    int prev, p, c0, ca;
    bit will_acc;

    // Reset
    i_clr = 1'b0;
    repeat (3) @(negedge clk);
    i_clr = 1'b1;
    @(negedge clk);
    check("rst_pos", int'(o_pos), 128);
    check("rst_busy", int'(o_busy), 0);
    check("rst_at_target", int'(o_at_target), 1);
    check("rst_ready", int'(o_cmd_ready), 1);

    // Move and settle: 128 -> 140
    send(140);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && k <= 16) check("move_pos", int'(o_pos), 128 + 3 * (k / 4));
      if (k == 16 || k == 20 || k == 23) check("settle_ready", int'(o_cmd_ready), 0);
      if (k == 24) begin
        check("settle_done_at", int'(o_at_target), 1);
        check("settle_done_rdy", int'(o_cmd_ready), 1);
      end
    end

    // Clamping and same-target commands
    send(250);
    wait_idle();
    check("clamp_hi", int'(o_pos), 230);
    send(5);
    wait_idle();
    check("clamp_lo", int'(o_pos), 20);
    send(20);
    repeat (4) begin
      check("same_no_busy", int'(o_busy), 0);
      @(negedge clk);
    end
    send(10);
    repeat (4) begin
      check("same_clamped_no_busy", int'(o_busy), 0);
      @(negedge clk);
    end

    // Retarget mid-move
    send(128);
    wait_idle();
    send(200);
    wait_pos(134);
    send(120);
    exp_seq[0] = 131; exp_seq[1] = 128; exp_seq[2] = 125; exp_seq[3] = 122; exp_seq[4] = 120;
    prev = 134;
    for (int i = 0; i < 5; i++) begin
      wait_change(prev);
      check("retarget_pos", int'(o_pos), exp_seq[i]);
      prev = int'(o_pos);
    end
    check("retarget_settle", int'(o_cmd_ready), 0);
    wait_idle();

    // Hold mid-move: 120 -> 140, nominal arrival 28 cycles after accept
    send(140);
    c0 = cyc;
    repeat (5) @(negedge clk);
    p = int'(o_pos);
    check("hold_start_pos", p, 123);
    i_hold = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_frozen", int'(o_pos), p);
    end
    i_hold = 1'b0;
    for (int i = 0; i < 200 && o_cmd_ready; i++) @(negedge clk);
    check("hold_arrival_delay", cyc - c0, 38);
    check("hold_arrival_pos", int'(o_pos), 140);
    ca = cyc;
    i_hold = 1'b1;
    wait_idle();
    check("hold_in_settle", cyc - ca, 8);
    i_hold = 1'b0;

    // Reset mid-move
    #2 i_clr = 1'b0;
    #2 i_clr = 1'b1;
    @(negedge clk);
    send(140);
    wait_pos(137);
    #2 i_clr = 1'b0;
    #1;
    check("midrst_pos", int'(o_pos), 128);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_at", int'(o_at_target), 1);
    #1 i_clr = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("midrst_still", int'(o_pos), 128);
    end

    // Random traffic
    will_acc = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      if (will_acc) i_cmd_valid = 1'b0;
      if (!i_cmd_valid && $urandom_range(0, 7) == 0) begin
        i_cmd_valid = 1'b1;
        i_cmd_pos   = 8'($urandom_range(0, 255));
      end
      i_hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 i_clr = 1'b0;
        #2 i_clr = 1'b1;
      end
      will_acc = i_cmd_valid && o_cmd_ready;
    end
    i_cmd_valid = 1'b0;
    i_hold = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
